// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: AVR external interrupt controller (EICR/EIMSK/EIFR) for up to 4 pin lines.
// Define EXTINT_FILTER_EN to add a 3-clock glitch filter on each synchronised line.
module ext_int_ctrl #(
    parameter int         LINES     = 2,
    parameter logic [5:0] ADR_EICR  = 6'h29,
    parameter logic [5:0] ADR_EIMSK = 6'h3B,
    parameter logic [5:0] ADR_EIFR  = 6'h3A
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic [5:0]       adr_i,
    input  logic [7:0]       data_i,
    output logic [7:0]       data_o,
    input  logic             re_i,
    input  logic             we_i,
    output logic             selected_o,
    input  logic [LINES-1:0] pin_i,
    output logic [LINES-1:0] irq_o,
    input  logic [LINES-1:0] irq_ack_i
);
    logic [2*LINES-1:0] r_eicr;
    logic [LINES-1:0]   r_eimsk, r_eifr, r_s1, r_s2, r_prev;
    logic [1:0]         r_warm;
    logic [LINES-1:0]   w_f, w_edge, w_set, w_clr;
    logic               w_warm, w_wr, w_hit_cr, w_hit_msk, w_hit_flg;

    assign w_warm     = r_warm == 2'd3;
    assign w_wr       = we_i & ena_i;
    assign w_hit_cr   = adr_i == ADR_EICR;
    assign w_hit_msk  = adr_i == ADR_EIMSK;
    assign w_hit_flg  = adr_i == ADR_EIFR;
    assign selected_o = (w_hit_cr | w_hit_msk | w_hit_flg) & re_i;
    assign data_o     = w_hit_cr  ? 8'(r_eicr)  :
                        w_hit_msk ? 8'(r_eimsk) :
                        w_hit_flg ? 8'(r_eifr)  : 8'h00;

`ifdef EXTINT_FILTER_EN
    // During warm-up the filter tracks s2 directly so it starts aligned with the pins.
    logic [LINES-1:0] r_fh;
    for (genvar g = 0; g < LINES; g++) begin : g_filt
        logic [1:0] r_cnt;
        assign w_f[g] = (!w_warm || (r_s2[g] != r_fh[g] && r_cnt == 2'd2)) ? r_s2[g] : r_fh[g];
        always_ff @(posedge clk_i)
            if (rst_i) r_cnt <= 2'd0;
            else r_cnt <= (!w_warm || r_s2[g] == r_fh[g] || r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
    end
    always_ff @(posedge clk_i) r_fh <= rst_i ? '0 : w_f;
`else
    assign w_f = r_s2;
`endif

    assign w_edge = w_warm ? (w_f ^ r_prev) : '0;
    assign w_clr  = irq_ack_i | ({LINES{w_wr & w_hit_flg}} & data_i[LINES-1:0]);

    for (genvar g = 0; g < LINES; g++) begin : g_line
        logic [1:0] w_sc;
        assign w_sc     = r_eicr[2*g +: 2];
        assign w_set[g] = w_edge[g] & (w_sc == 2'b01 | (w_sc == 2'b10 & ~w_f[g]) | (w_sc == 2'b11 & w_f[g]));
        assign irq_o[g] = w_sc == 2'b00 ? r_eimsk[g] & ~w_f[g] : r_eifr[g] & r_eimsk[g];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_eicr  <= '0;
            r_eimsk <= '0;
            r_eifr  <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_prev  <= '0;
            r_warm  <= 2'd0;
        end else begin
            r_s1   <= pin_i;
            r_s2   <= r_s1;
            r_prev <= w_f;
            r_warm <= w_warm ? r_warm : r_warm + 2'd1;
            r_eifr <= w_set | (r_eifr & ~w_clr);
            if (w_wr & w_hit_cr)  r_eicr  <= data_i[2*LINES-1:0];
            if (w_wr & w_hit_msk) r_eimsk <= data_i[LINES-1:0];
        end
    end
endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb_ext_int_ctrl: directed and randomized bench for ext_int_ctrl against a pin-history reference model.
module tb_ext_int_ctrl;
    localparam int         LINES   = 2;
    localparam logic [5:0] A_CR    = 6'h29;
    localparam logic [5:0] A_MSK   = 6'h3B;
    localparam logic [5:0] A_FLG   = 6'h3A;
    localparam logic [7:0] CR_MASK = 8'((1 << (2*LINES)) - 1);
`ifdef EXTINT_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i, ena_i, re_i, we_i, selected_o;
    logic [5:0]       adr_i;
    logic [7:0]       data_i, data_o;
    logic [LINES-1:0] pin_i, irq_o, irq_ack_i;

    int checks = 0;
    int errors = 0;

    // model: registers, line value seen now and one interval ago, recent pin samples (samp[0] newest)
    logic [7:0]       m_cr;
    logic [LINES-1:0] m_msk, m_flg, m_l, m_lold;
    logic [LINES-1:0] samp [4];
    int               cyc;

    ext_int_ctrl #(.LINES(LINES)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .adr_i(adr_i), .data_i(data_i),
        .data_o(data_o), .re_i(re_i), .we_i(we_i), .selected_o(selected_o),
        .pin_i(pin_i), .irq_o(irq_o), .irq_ack_i(irq_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_rd();
        return adr_i == A_CR ? m_cr : adr_i == A_MSK ? 8'(m_msk) : adr_i == A_FLG ? 8'(m_flg) : 8'h00;
    endfunction

    function automatic logic [LINES-1:0] m_irq();
        logic [LINES-1:0] r;
        for (int n = 0; n < LINES; n++)
            r[n] = m_cr[2*n +: 2] == 2'b00 ? m_msk[n] & ~m_l[n] : m_flg[n] & m_msk[n];
        return r;
    endfunction

    task automatic model_edge();
        logic [LINES-1:0] set, clr, edg;
`ifdef EXTINT_FILTER_EN
        logic [LINES-1:0] agree;
`endif
        if (rst_i) begin
            m_cr = '0; m_msk = '0; m_flg = '0; m_l = '0; m_lold = '0; cyc = 0;
            for (int i = 0; i < 4; i++) samp[i] = '0;
            return;
        end
        cyc++;
        for (int i = 3; i > 0; i--) samp[i] = samp[i-1];
        samp[0] = pin_i;
        edg = (cyc - 1 >= 3) ? (m_l ^ m_lold) : '0;
        for (int n = 0; n < LINES; n++)
            case (m_cr[2*n +: 2])
                2'b01:   set[n] = edg[n];
                2'b10:   set[n] = edg[n] & ~m_l[n];
                2'b11:   set[n] = edg[n] & m_l[n];
                default: set[n] = 1'b0;
            endcase
        clr   = irq_ack_i | ((we_i && ena_i && adr_i == A_FLG) ? data_i[LINES-1:0] : '0);
        m_flg = set | (m_flg & ~clr);
        if (we_i && ena_i && adr_i == A_CR)  m_cr  = data_i & CR_MASK;
        if (we_i && ena_i && adr_i == A_MSK) m_msk = data_i[LINES-1:0];
        m_lold = m_l;
`ifdef EXTINT_FILTER_EN
        // filtered line follows the pin once three consecutive synchronised samples agree
        agree = ~(samp[1] ^ samp[2]) & ~(samp[2] ^ samp[3]);
        m_l   = (cyc >= 3) ? ((agree & samp[1]) | (~agree & m_l)) : samp[1];
`else
        m_l = samp[1];
`endif
    endtask

    task automatic cycle();
        #1;
        check("data_o", data_o, m_rd());
        check("selected_o", 8'(selected_o), 8'(re_i && (adr_i == A_CR || adr_i == A_MSK || adr_i == A_FLG)));
        check("irq_o", 8'(irq_o), 8'(m_irq()));
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        adr_i = a; data_i = d; we_i = 1'b1;
        cycle();
        we_i = 1'b0; adr_i = 6'h00; data_i = 8'h00;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string tag);
        adr_i = a; re_i = 1'b1;
        #1;
        check(tag, data_o, exp);
        check({tag, "_sel"}, 8'(selected_o), 8'h01);
        cycle();
        re_i = 1'b0; adr_i = 6'h00;
    endtask

    initial begin
        rst_i = 1'b1; ena_i = 1'b1; re_i = 1'b0; we_i = 1'b0;
        adr_i = 6'h00; data_i = 8'h00; pin_i = '1; irq_ack_i = '0;
        repeat (2) begin
            @(posedge clk_i);
            model_edge();
        end
        #1 rst_i = 1'b0;

        // pins high through reset, rising mode: no spurious flag
        wr(A_CR, 8'h03);
        repeat (6) cycle();
        rd(A_FLG, 8'h00, "warm_eifr");
        check("warm_irq", 8'(irq_o), 8'h00);

        // falling edge latency on line 0
        wr(A_CR, 8'h02);
        wr(A_MSK, 8'h01);
        pin_i[0] = 1'b0;
        cycle();
        check("fall_lat0", 8'(irq_o[0]), 8'h00);
        for (int m = 1; m <= LAT; m++) begin
            cycle();
            check("fall_lat", 8'(irq_o[0]), 8'(m == LAT));
        end
        rd(A_FLG, 8'h01, "fall_eifr");

        // acknowledge clears, collision with a new edge keeps the flag
        irq_ack_i[0] = 1'b1;
        cycle();
        irq_ack_i[0] = 1'b0;
        check("ack_clr", 8'(irq_o[0]), 8'h00);
        wr(A_CR, 8'h01);
        pin_i[0] = 1'b1;
        repeat (LAT) cycle();
        irq_ack_i[0] = 1'b1;
        cycle();
        irq_ack_i[0] = 1'b0;
        check("set_wins", 8'(irq_o[0]), 8'h01);
        rd(A_FLG, 8'h01, "set_wins_eifr");

        // low-level mode
        wr(A_FLG, 8'h03);
        wr(A_CR, 8'h00);
        pin_i[0] = 1'b0;
        repeat (LAT + 2) cycle();
        check("level_on", 8'(irq_o[0]), 8'h01);
        rd(A_FLG, 8'h00, "level_eifr");
        pin_i[0] = 1'b1;
        cycle();
        check("level_hold", 8'(irq_o[0]), 8'h01);
        repeat (LAT + 1) cycle();
        check("level_off", 8'(irq_o[0]), 8'h00);

        // line 1 any edge, flag independent of mask
        wr(A_CR, 8'h04);
        wr(A_MSK, 8'h00);
        pin_i[1] = ~pin_i[1];
        repeat (LAT + 2) cycle();
        rd(A_FLG, 8'h02, "line1_flag");
        check("line1_masked", 8'(irq_o), 8'h00);
        wr(A_MSK, 8'h02);
        check("line1_irq", 8'(irq_o), 8'h02);
        wr(A_FLG, 8'h02);
        rd(A_FLG, 8'h00, "line1_w1c");

`ifdef EXTINT_FILTER_EN
        // glitch filter: 2-clock low ignored, 3-clock low detected at k+4
        wr(A_CR, 8'h02);
        wr(A_MSK, 8'h01);
        wr(A_FLG, 8'h03);
        pin_i[0] = 1'b0;
        repeat (2) cycle();
        pin_i[0] = 1'b1;
        repeat (6) cycle();
        rd(A_FLG, 8'h00, "glitch2");
        pin_i[0] = 1'b0;
        for (int m = 0; m <= 4; m++) begin
            if (m == 3) pin_i[0] = 1'b1;
            cycle();
            check("pulse3", 8'(irq_o[0]), 8'(m == 4));
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            rst_i = $urandom_range(0, 299) == 0;
            ena_i = $urandom_range(0, 3) != 0;
            we_i  = $urandom_range(0, 5) == 0;
            re_i  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       adr_i = A_CR;
                1:       adr_i = A_MSK;
                2:       adr_i = A_FLG;
                default: adr_i = 6'($urandom);
            endcase
            data_i = 8'($urandom);
            for (int n = 0; n < LINES; n++) begin
                irq_ack_i[n] = $urandom_range(0, 7) == 0;
                if ($urandom_range(0, 3) == 0) pin_i[n] = ~pin_i[n];
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
